// File: rtl/usb_tx.sv
// USB full-speed transmitter: SYNC, PID, optional payload + CRC16, EOP, with bit stuffing and NRZI.
// First SYNC bit one cycle after accept; FIFO is popped by get_tx_packet_data, no stall once sending.
module usb_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] tx_packet,
    input  logic [7:0] tx_packet_data,
    input  logic [6:0] buffer_occupancy,
    output logic       get_tx_packet_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_transfer_active,
    output logic       tx_error
);
    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    MAX_P     = 8'(MAX_PAYLOAD);
    localparam logic [7:0]    SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC, EOP_SE0, EOP_J} state_t;

    state_t        state, state_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    ones;
    logic [7:0]    pid_byte, pid_sel, data_byte;
    logic          is_data;
    logic [6:0]    n_bytes, byte_cnt;
    logic [15:0]   crc;
    logic          level;

    logic cmd_ok, cmd_data, cmd_reject;
    logic accept, bit_end, stuff, send_bit, emit_bit, pop;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {1'b0, c[15:1]} ^ ((c[0] ^ b) ? 16'hA001 : 16'h0000);
    endfunction

    always_comb begin
        pid_sel = 8'h00;
        case (tx_packet)
            4'd1:    pid_sel = 8'hC3;
            4'd2:    pid_sel = 8'h4B;
            4'd3:    pid_sel = 8'hD2;
            4'd4:    pid_sel = 8'h5A;
            4'd5:    pid_sel = 8'h1E;
            default: pid_sel = 8'h00;
        endcase
    end

    assign cmd_ok     = (tx_packet != 4'd0) && (tx_packet <= 4'd5);
    assign cmd_data   = (tx_packet == 4'd1) || (tx_packet == 4'd2);
    assign cmd_reject = cmd_data && ({1'b0, buffer_occupancy} > MAX_P);

    assign tx_transfer_active = (state != IDLE);
    assign get_tx_packet_data = pop;

    // state/idx name the field and bit currently on the wire; a stuff bit keeps them in place
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        accept    = 1'b0;
        bit_end   = 1'b0;
        stuff     = 1'b0;
        send_bit  = 1'b0;
        emit_bit  = 1'b0;
        pop       = 1'b0;
        if (state == IDLE) begin
            if (cmd_ok && !cmd_reject) begin
                accept    = 1'b1;
                state_nxt = SYNC;
                idx_nxt   = 4'd0;
                send_bit  = 1'b1;
                emit_bit  = SYNC_BYTE[0];
            end
        end else if (bit_cnt == LAST) begin
            bit_end = 1'b1;
            if (ones == 3'd6) begin
                stuff = 1'b1;
            end else begin
                case (state)
                    SYNC: begin
                        if (idx == 4'd7) begin
                            state_nxt = PID;
                            idx_nxt   = 4'd0;
                        end else begin
                            idx_nxt = idx + 4'd1;
                        end
                    end
                    PID: begin
                        if (idx == 4'd7) begin
                            idx_nxt = 4'd0;
                            if (!is_data)               state_nxt = EOP_SE0;
                            else if (n_bytes == 7'd0)   state_nxt = CRC;
                            else                        state_nxt = DATA;
                        end else begin
                            idx_nxt = idx + 4'd1;
                        end
                    end
                    DATA: begin
                        if (idx == 4'd7) begin
                            idx_nxt   = 4'd0;
                            state_nxt = (byte_cnt == n_bytes - 7'd1) ? CRC : DATA;
                        end else begin
                            idx_nxt = idx + 4'd1;
                        end
                    end
                    CRC: begin
                        if (idx == 4'd15) begin
                            state_nxt = EOP_SE0;
                            idx_nxt   = 4'd0;
                        end else begin
                            idx_nxt = idx + 4'd1;
                        end
                    end
                    EOP_SE0: begin
                        if (idx == 4'd1) begin
                            state_nxt = EOP_J;
                            idx_nxt   = 4'd0;
                        end else begin
                            idx_nxt = idx + 4'd1;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        idx_nxt   = 4'd0;
                    end
                endcase

                pop      = (state_nxt == DATA) && (idx_nxt == 4'd0);
                send_bit = (state_nxt == SYNC) || (state_nxt == PID) ||
                           (state_nxt == DATA) || (state_nxt == CRC);
                case (state_nxt)
                    SYNC:    emit_bit = SYNC_BYTE[idx_nxt[2:0]];
                    PID:     emit_bit = pid_byte[idx_nxt[2:0]];
                    DATA:    emit_bit = pop ? tx_packet_data[0] : data_byte[idx_nxt[2:0]];
                    CRC:     emit_bit = ~crc[idx_nxt];
                    default: emit_bit = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 4'd0;
            bit_cnt    <= '0;
            ones       <= 3'd0;
            pid_byte   <= 8'h00;
            is_data    <= 1'b0;
            n_bytes    <= 7'd0;
            byte_cnt   <= 7'd0;
            data_byte  <= 8'h00;
            crc        <= 16'hFFFF;
            level      <= 1'b1;
            dplus_out  <= 1'b1;
            dminus_out <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            tx_error <= (state == IDLE) && cmd_ok && cmd_reject;

            if (accept) begin
                pid_byte <= pid_sel;
                is_data  <= cmd_data;
                n_bytes  <= cmd_data ? buffer_occupancy : 7'd0;
                byte_cnt <= 7'd0;
                crc      <= 16'hFFFF;
                bit_cnt  <= '0;
            end else if (state != IDLE) begin
                bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
            end

            if (pop)
                data_byte <= tx_packet_data;
            if (bit_end && !stuff && (state == DATA) && (idx == 4'd7))
                byte_cnt <= byte_cnt + 7'd1;

            // NRZI: a logical 0 (including a stuff bit) flips the line, a 1 holds it
            if (stuff) begin
                level      <= ~level;
                dplus_out  <= ~level;
                dminus_out <= level;
                ones       <= 3'd0;
            end else if (send_bit) begin
                if (!emit_bit) begin
                    level      <= ~level;
                    dplus_out  <= ~level;
                    dminus_out <= level;
                end
                ones <= emit_bit ? ones + 3'd1 : 3'd0;
                if (state_nxt == DATA)
                    crc <= crc16_step(crc, emit_bit);
            end else if (bit_end) begin
                ones <= 3'd0;
                if (state_nxt == EOP_SE0) begin
                    dplus_out  <= 1'b0;
                    dminus_out <= 1'b0;
                end else begin
                    dplus_out  <= 1'b1;
                    dminus_out <= 1'b0;
                    level      <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: captures the wire per cycle, decodes NRZI/stuffing, checks bytes and timing.
module tb_usb_tx;
    localparam int         CPB = 4;
    localparam logic [1:0] SJ  = 2'b10;
    localparam logic [1:0] SK  = 2'b01;
    localparam logic [1:0] S0  = 2'b00;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] tx_packet;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       get_tx_packet_data;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_transfer_active;
    logic       tx_error;

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_mem [0:255];
    int         pop_total = 0;

    logic [1:0] wire_q[$];
    int         pop_at[$];
    logic [7:0] dec_bytes[$];
    int         dec_pos[$];
    int         dec_stuff, dec_err, hold_err;
    logic       eop_ok;
    logic [7:0] exp_bytes[$];
    logic [1:0] ack_exp [19];

    always #5 clk = ~clk;

    always @(posedge clk) if (get_tx_packet_data) pop_total <= pop_total + 1;
    assign tx_packet_data = fifo_mem[pop_total[7:0]];

    usb_tx #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_packet          (tx_packet),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .get_tx_packet_data (get_tx_packet_data),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input int first, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ exp_bytes[first + i][b]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return c;
    endfunction

    function automatic int stuff_of();
        int ones = 0;
        int cnt  = 0;
        foreach (exp_bytes[i])
            for (int b = 0; b < 8; b++) begin
                if (exp_bytes[i][b]) begin
                    ones++;
                    if (ones == 6) begin
                        cnt++;
                        ones = 0;
                    end
                end else begin
                    ones = 0;
                end
            end
        return cnt;
    endfunction

    // Issue one command, then record the line every cycle while the packet is active.
    task automatic send(input logic [3:0] cmd, input logic [6:0] occ, input int inj_at, input logic [3:0] inj_cmd);
        int guard;
        wire_q.delete();
        pop_at.delete();
        @(negedge clk);
        tx_packet        = cmd;
        buffer_occupancy = occ;
        @(negedge clk);
        tx_packet = 4'd0;
        guard = 0;
        while (tx_transfer_active && guard < 4000) begin
            wire_q.push_back({dplus_out, dminus_out});
            if (get_tx_packet_data) pop_at.push_back(wire_q.size() - 1);
            tx_packet = (guard == inj_at) ? inj_cmd : 4'd0;
            @(negedge clk);
            guard++;
        end
        tx_packet = 4'd0;
        chk("packet_ends", 32'(guard < 4000), 1);
    endtask

    task automatic decode();
        logic [1:0] prev, s;
        logic [7:0] sh;
        logic       b;
        int         ones, nb, start, nbits, k;
        dec_bytes.delete();
        dec_pos.delete();
        dec_stuff = 0;
        dec_err   = 0;
        hold_err  = 0;
        eop_ok    = 1'b0;
        prev  = SJ;
        ones  = 0;
        nb    = 0;
        start = 0;
        sh    = 8'h00;
        nbits = wire_q.size() / CPB;
        if (wire_q.size() % CPB != 0) hold_err++;
        for (int i = 0; i < nbits; i++)
            for (int j = 1; j < CPB; j++)
                if (wire_q[i*CPB + j] !== wire_q[i*CPB]) hold_err++;
        k = 0;
        while (k < nbits && wire_q[k*CPB] != S0) begin
            s = wire_q[k*CPB];
            if (s != SJ && s != SK) dec_err++;
            b    = (s == prev);
            prev = s;
            if (ones == 6) begin
                if (b) dec_err++;
                dec_stuff++;
                ones = 0;
            end else begin
                if (nb == 0) start = k;
                sh = {b, sh[7:1]};
                nb++;
                ones = b ? ones + 1 : 0;
                if (nb == 8) begin
                    dec_bytes.push_back(sh);
                    dec_pos.push_back(start);
                    nb = 0;
                end
            end
            k++;
        end
        if (nb != 0) dec_err++;
        if (nbits - k == 3)
            eop_ok = (wire_q[k*CPB] == S0) && (wire_q[(k+1)*CPB] == S0) && (wire_q[(k+2)*CPB] == SJ);
    endtask

    task automatic verify(input string tag, input int n, input int pops_before);
        int bad;
        decode();
        chk({tag, "_eop"}, 32'(eop_ok), 1);
        chk({tag, "_decode_err"}, dec_err, 0);
        chk({tag, "_bit_hold"}, hold_err, 0);
        chk({tag, "_nbytes"}, dec_bytes.size(), exp_bytes.size());
        bad = 0;
        foreach (exp_bytes[i])
            if (i >= dec_bytes.size() || dec_bytes[i] !== exp_bytes[i]) bad++;
        chk({tag, "_bytes"}, bad, 0);
        chk({tag, "_stuff_count"}, dec_stuff, stuff_of());
        chk({tag, "_active_cycles"}, wire_q.size(), CPB * (8 * exp_bytes.size() + stuff_of() + 3));
        chk({tag, "_pops_active"}, pop_at.size(), n);
        chk({tag, "_pops_total"}, pop_total - pops_before, n);
        bad = 0;
        foreach (pop_at[i])
            if (2 + i >= dec_pos.size() || pop_at[i] + 1 != CPB * dec_pos[2 + i]) bad++;
        chk({tag, "_pop_timing"}, bad, 0);
    endtask

    initial begin
        int p0, bad;
        logic [15:0] c;
        rst              = 1'b1;
        tx_packet        = 4'd0;
        buffer_occupancy = 7'd0;
        for (int i = 0; i < 256; i++) fifo_mem[i] = 8'h00;
        ack_exp = '{SK, SJ, SK, SJ, SK, SJ, SK, SK,
                    SJ, SJ, SK, SJ, SJ, SK, SK, SK,
                    S0, S0, SJ};
        repeat (3) @(negedge clk);
        chk("rst_dplus", 32'(dplus_out), 1);
        chk("rst_dminus", 32'(dminus_out), 0);
        chk("rst_active", 32'(tx_transfer_active), 0);
        chk("rst_get", 32'(get_tx_packet_data), 0);
        chk("rst_error", 32'(tx_error), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ACK handshake: exact line sequence
        p0 = pop_total;
        send(4'd3, 7'd0, -1, 4'd0);
        exp_bytes = '{8'h80, 8'hD2};
        verify("ack", 0, p0);
        chk("ack_cycles", wire_q.size(), 76);
        bad = 0;
        for (int i = 0; i < 19; i++)
            if (wire_q[i*CPB] !== ack_exp[i]) bad++;
        chk("ack_line_seq", bad, 0);

        // DATA0 with empty payload: CRC goes out as 0x0000
        p0 = pop_total;
        send(4'd1, 7'd0, -1, 4'd0);
        exp_bytes = '{8'h80, 8'hC3, 8'h00, 8'h00};
        verify("data0_n0", 0, p0);
        chk("data0_n0_cycles", wire_q.size(), 140);

        // DATA1 with one 0xFF byte: stuffing in payload and in CRC high byte
        p0 = pop_total;
        fifo_mem[8'(p0)] = 8'hFF;
        send(4'd2, 7'd1, -1, 4'd0);
        exp_bytes = '{8'h80, 8'h4B, 8'hFF, 8'h00, 8'hFF};
        verify("data1_ff", 1, p0);
        chk("data1_ff_stuffs", dec_stuff, 2);
        chk("data1_ff_cycles", wire_q.size(), 180);

        // Maximum payload, incrementing bytes
        p0 = pop_total;
        exp_bytes = '{8'h80, 8'hC3};
        for (int i = 0; i < 64; i++) begin
            fifo_mem[8'(p0 + i)] = 8'(i);
            exp_bytes.push_back(8'(i));
        end
        c = ~crc_of(2, 64);
        exp_bytes.push_back(c[7:0]);
        exp_bytes.push_back(c[15:8]);
        send(4'd1, 7'd64, -1, 4'd0);
        verify("max64", 64, p0);

        // Oversized payload is rejected; an undefined command is ignored
        @(negedge clk);
        tx_packet        = 4'd1;
        buffer_occupancy = 7'd65;
        @(negedge clk);
        tx_packet = 4'd0;
        chk("rej_error_pulse", 32'(tx_error), 1);
        chk("rej_active", 32'(tx_transfer_active), 0);
        chk("rej_line", {30'd0, dplus_out, dminus_out}, 32'(SJ));
        @(negedge clk);
        chk("rej_error_clear", 32'(tx_error), 0);
        tx_packet = 4'd7;
        @(negedge clk);
        tx_packet = 4'd0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_transfer_active || tx_error || !dplus_out || dminus_out) bad++;
            @(negedge clk);
        end
        chk("rej_idle_quiet", bad, 0);

        // Reset in the middle of a payload
        p0 = pop_total;
        for (int i = 0; i < 8; i++) fifo_mem[8'(p0 + i)] = 8'hA5;
        @(negedge clk);
        tx_packet        = 4'd1;
        buffer_occupancy = 7'd8;
        @(negedge clk);
        tx_packet = 4'd0;
        repeat (80) @(negedge clk);
        chk("mid_active", 32'(tx_transfer_active), 1);
        chk("mid_popped", 32'(pop_total - p0 > 0), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_line", {30'd0, dplus_out, dminus_out}, 32'(SJ));
        chk("mid_rst_active", 32'(tx_transfer_active), 0);
        chk("mid_rst_get", 32'(get_tx_packet_data), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // NAK, then STALL 10 cycles later while busy: STALL is dropped
        p0 = pop_total;
        send(4'd4, 7'd0, 9, 4'd5);
        exp_bytes = '{8'h80, 8'h5A};
        verify("nak", 0, p0);
        chk("nak_cycles", wire_q.size(), 76);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_transfer_active) bad++;
            @(negedge clk);
        end
        chk("stall_ignored", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_tx.md
Name: usb_tx

Overview:
USB full-speed serial transmitter. It is the transmit-side counterpart of the USB receive path and shares that path's 4-bit packet encoding and its 7-bit buffer occupancy convention. On a command from the protocol controller it serialises one packet onto D+/D-:
- SYNC, then PID.
- For data packets only: payload bytes pulled from the TX FIFO, then CRC16.
- EOP.
Bit stuffing and NRZI encoding are applied on the way out.

Parameters:
CLKS_PER_BIT, 4, system clocks per USB bit time (48 MHz clk gives 12 Mbps); must be at least 2.
MAX_PAYLOAD, 64, largest legal data payload in bytes.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
tx_packet  input  4  command: 0 none, 1 DATA0, 2 DATA1, 3 ACK, 4 NAK, 5 STALL, other values ignored.
tx_packet_data  input  8  FIFO head byte; must be valid whenever get_tx_packet_data is high.
buffer_occupancy  input  7  FIFO byte count; sampled at command accept.
get_tx_packet_data  output  1  one-cycle FIFO pop strobe.
dplus_out  output  1  D+ line.
dminus_out  output  1  D- line.
tx_transfer_active  output  1  high while a packet is on the wire.
tx_error  output  1  one-cycle pulse on a rejected command.

Behaviour:
- **Reset values:** dplus_out=1, dminus_out=0 (J/idle); get_tx_packet_data=0; tx_transfer_active=0; tx_error=0; state IDLE; NRZI level J; stuff counter 0; CRC 0xFFFF.
- **Command accept:** in IDLE with tx_packet in 1..5, the command is latched on that edge.
  - For DATA0/DATA1, byte count N = buffer_occupancy is also latched.
  - The first SYNC bit appears on the next cycle, and tx_transfer_active rises on that same cycle.
  - tx_packet is ignored outside IDLE.
- **Rejected command:** DATA0/DATA1 with N > MAX_PAYLOAD gives a one-cycle tx_error pulse. Nothing is transmitted and the state stays IDLE.
- **Bit timer:** a counter runs 0..CLKS_PER_BIT-1 while active. The line updates only when the counter equals 0, so each wire bit lasts exactly CLKS_PER_BIT cycles.
- **PID bytes:** {~pid, pid}. DATA0=0xC3, DATA1=0x4B, ACK=0xD2, NAK=0x5A, STALL=0x1E.
- **Bit order:** all bytes are sent LSB first. SYNC byte is 0x80.
- **States:** IDLE -> SYNC(8 bits) -> PID(8) -> {handshake: EOP_SE0} {data: DATA if N>0 else CRC} ; DATA -> CRC after N bytes ; CRC(16 bits) -> EOP_SE0 ; EOP_SE0 (2 bit times) -> EOP_J (1 bit time) -> IDLE.
- **Stuffing and NRZI:**
  - Logical bit 0 toggles the line level between J(1,0) and K(0,1); logical bit 1 holds it.
  - After six consecutive logical 1s, including runs that cross byte or field boundaries, a stuffed 0 is inserted. The stuff bit consumes one bit time and does not advance the bit index.
  - The stuff counter clears at SYNC start.
  - No stuffing is applied during EOP.
  - If the sixth 1 is the last CRC bit (or the last PID bit of a handshake), its stuff bit is sent before EOP.
- **EOP:** SE0 (dplus_out=0, dminus_out=0) for 2 bit times, then J for 1 bit time. tx_transfer_active falls on the cycle the state returns to IDLE. The NRZI level resets to J.
- **FIFO pop:** get_tx_packet_data pulses for one cycle at the start of each payload byte's first bit time. tx_packet_data is captured into the shift register on that same edge. There are exactly N pulses per data packet.
- **CRC16:**
  - Polynomial x^16+x^15+x^2+1.
  - Initialised to 0xFFFF at PID end.
  - Updated per payload bit, LSB first, excluding stuff bits.
  - Transmitted as the bitwise complement, bit 0 first.
  - For N=0 the transmitted CRC is 0x0000.
- **Underflow:** buffer_occupancy is not rechecked after accept. FIFO emptiness during a packet is the controller's responsibility.
- **Reset mid-packet:** all outputs return to reset values asynchronously. No EOP is sent.

Test Plan:
- **ACK:** tx_packet=3 for 1 cycle, CLKS_PER_BIT=4 -> tx_transfer_active high for exactly 76 cycles (19 bit times). SYNC line sequence K J K J K J K K. PID 0xD2 bits 0,1,0,0,1,0,1,1. SE0 for 8 cycles, J for 4 cycles. No get_tx_packet_data pulse.
- **DATA0, N=0:** buffer_occupancy=0 -> PID 0xC3, then 16 logical zeros (CRC 0x0000), EOP. Active for 35 bit times. Zero pops.
- **Bit stuffing:** DATA1, N=1, byte 0xFF -> one pop. A stuffed 0 (line toggle) is inserted after the sixth payload 1. The total stuff-bit count matches a golden model. Decoding the line with the existing usb_rx yields data 0xFF and rx_error=0.
- **Max payload:** DATA0, N=64, incrementing bytes 0x00..0x3F -> exactly 64 pops, each 8 bit times apart excluding stuff bits. A loopback through usb_rx receives all 64 bytes and a good CRC.
- **Rejected command:** DATA0 with buffer_occupancy=65 -> tx_error high for 1 cycle. Lines stay J, tx_transfer_active stays 0.
- **Reset mid-packet and command while busy:** assert rst during DATA -> lines go J and active=0 immediately. Then NAK followed by STALL issued 10 cycles later -> only the NAK (0x5A) is sent and STALL is ignored.
